// File: rtl/rr_pri_ctrl.sv
// Round-robin state stage for the programmable priority arbiter: drives p/r_arb, registers and holds the grant.
// Optional starvation guard compiled in with `define STARVE_GUARD_EN.
module rr_pri_ctrl #(
    parameter int N       = 8,
    parameter int WAITW   = 4,
    parameter int MAXWAIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] r_in,
    input  logic         done,
    input  logic [N-1:0] g_arb,
    output logic [N-1:0] r_arb,
    output logic [N-1:0] p,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         err,
    output logic         starve
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    if (N < 2 || MAXWAIT < 1 || MAXWAIT >= (1 << WAITW)) begin : g_bad_cfg
        $error("rr_pri_ctrl: need N>=2 and 1<=MAXWAIT<2**WAITW");
    end

    state_t       state_q, state_d;
    logic [N-1:0] ptr_q, ptr_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic         err_q, err_d;
    logic         g_multi, g_one, grant_ev;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign g_multi = |(g_arb & (g_arb - ONE));
    assign g_one   = (|g_arb) && !g_multi;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        err_d    = err_q;
        r_arb    = '0;
        grant_ev = 1'b0;
        case (state_q)
            IDLE: begin
                r_arb = r_in;
                if (g_multi) begin
                    err_d = 1'b1;
                end else if (g_one) begin
                    gnt_d    = g_arb;
                    state_d  = HOLD;
                    ptr_d    = {g_arb[N-2:0], g_arb[N-1]};
                    grant_ev = 1'b1;
                end
            end
            HOLD: begin
                if (done || ((r_in & gnt_q) == '0)) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= ONE;
            gnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == HOLD);
    assign err  = err_q;

`ifdef STARVE_GUARD_EN
    logic [WAITW-1:0] wait_q [N];

    // NOTE: the wait counters are a small register array, not RAM, so they are reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) wait_q[i] <= '0;
        end else if (grant_ev) begin
            for (int i = 0; i < N; i++) begin
                if (!r_in[i] || g_arb[i]) wait_q[i] <= '0;
                else if (wait_q[i] != '1) wait_q[i] <= wait_q[i] + 1'b1;
            end
        end
    end

    // Scan downward so the lowest starving index is the last to win.
    always_comb begin
        p      = ptr_q;
        starve = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (wait_q[i] >= WAITW'(MAXWAIT)) begin
                p      = '0;
                p[i]   = 1'b1;
                starve = 1'b1;
            end
        end
    end
`else
    logic unused_grant_ev;
    assign unused_grant_ev = grant_ev;
    assign p               = ptr_q;
    assign starve          = 1'b0;
`endif

endmodule

// File: tb/tb_rr_pri_ctrl.sv
// Directed bench for rr_pri_ctrl with a behavioural programmable priority arbiter closing the loop.
// Define STARVE_GUARD_EN to also exercise the starvation guard (built with MAXWAIT=2).
module tb_rr_pri_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] r_in;
    logic         done;
    logic [N-1:0] g_arb;
    logic [N-1:0] r_arb;
    logic [N-1:0] p;
    logic [N-1:0] gnt;
    logic         busy;
    logic         err;
    logic         starve;

    logic         force_en;
    logic [N-1:0] force_val;
    logic [N-1:0] arb_g;

    int checks;
    int errors;

    rr_pri_ctrl #(.N(N), .WAITW(4), .MAXWAIT(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .r_in   (r_in),
        .done   (done),
        .g_arb  (g_arb),
        .r_arb  (r_arb),
        .p      (p),
        .gnt    (gnt),
        .busy   (busy),
        .err    (err),
        .starve (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Programmable priority arbiter: first request at or after the one-hot priority, wrapping.
    always_comb begin
        int pidx;
        int idx;
        arb_g = '0;
        pidx  = 0;
        idx   = 0;
        for (int i = 0; i < N; i++) if (p[i]) pidx = i;
        for (int k = 0; k < N; k++) begin
            idx = (pidx + k) % N;
            if (arb_g == '0 && r_arb[idx]) arb_g[idx] = 1'b1;
        end
    end

    assign g_arb = force_en ? force_val : arb_g;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; r_in = '0; done = 1'b0; force_en = 1'b0; force_val = '0;
        #12;
        checks++; if (p !== 8'h01) begin errors++; $display("FAIL reset_p got %h want 01", p); end
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got %h want 00", gnt); end
        checks++; if (busy !== 1'b0 || err !== 1'b0 || starve !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b err=%b starve=%b want 0 0 0", busy, err, starve);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_rotation();
        r_in = 8'h05;
        step();
        checks++; if (gnt !== 8'h01 || p !== 8'h02) begin errors++; $display("FAIL rot_first got gnt=%h p=%h want 01 02", gnt, p); end
        checks++; if (busy !== 1'b1 || r_arb !== 8'h00) begin errors++; $display("FAIL rot_hold got busy=%b r_arb=%h want 1 00", busy, r_arb); end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++; if (gnt !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rot_release got gnt=%h busy=%b want 00 0", gnt, busy); end
        checks++; if (r_arb !== 8'h05) begin errors++; $display("FAIL rot_idle_rarb got %h want 05", r_arb); end
        step();
        checks++; if (gnt !== 8'h04 || p !== 8'h08) begin errors++; $display("FAIL rot_second got gnt=%h p=%h want 04 08", gnt, p); end
        r_in = 8'h00;
        step();
        checks++; if (gnt !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rot_drop got gnt=%h busy=%b want 00 0", gnt, busy); end
    endtask

    task automatic test_wrap();
        r_in = 8'h80;
        step();
        checks++; if (gnt !== 8'h80 || p !== 8'h01) begin errors++; $display("FAIL wrap got gnt=%h p=%h want 80 01", gnt, p); end
        r_in = 8'h00;
        step();
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL wrap_release got gnt=%h want 00", gnt); end
    endtask

    task automatic test_hold_abandon();
        r_in = 8'h04;
        step();
        checks++; if (gnt !== 8'h04 || p !== 8'h08) begin errors++; $display("FAIL hold_grant got gnt=%h p=%h want 04 08", gnt, p); end
        r_in = 8'hFF;
        #1;
        checks++; if (r_arb !== 8'h00) begin errors++; $display("FAIL hold_rarb got %h want 00", r_arb); end
        step();
        checks++; if (gnt !== 8'h04 || busy !== 1'b1) begin errors++; $display("FAIL hold_stable got gnt=%h busy=%b want 04 1", gnt, busy); end
        r_in = 8'hFB;
        step();
        checks++; if (gnt !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL abandon got gnt=%h busy=%b want 00 0", gnt, busy); end
        r_in = 8'h00;
        step();
        checks++; if (gnt !== 8'h00 || p !== 8'h08) begin errors++; $display("FAIL abandon_idle got gnt=%h p=%h want 00 08", gnt, p); end
    endtask

    task automatic test_error();
        force_en = 1'b1; force_val = 8'h03; r_in = 8'h03;
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
        checks++; if (gnt !== 8'h00 || busy !== 1'b0 || p !== 8'h08) begin
            errors++; $display("FAIL err_nogrant got gnt=%h busy=%b p=%h want 00 0 08", gnt, busy, p);
        end
        force_en = 1'b0; r_in = 8'h00;
        step();
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        r_in = 8'h01;
        step();
        checks++; if (gnt !== 8'h01 || p !== 8'h02) begin errors++; $display("FAIL mid_grant got gnt=%h p=%h want 01 02", gnt, p); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (p !== 8'h01 || gnt !== 8'h00) begin errors++; $display("FAIL mid_reset got p=%h gnt=%h want 01 00", p, gnt); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got busy=%b err=%b want 0 0", busy, err); end
        r_in = 8'h00;
        #3;
        rst_n = 1'b1;
        step();
    endtask

`ifdef STARVE_GUARD_EN
    task automatic test_guard();
        force_en = 1'b1; force_val = 8'h01; r_in = 8'h21;
        step();
        checks++; if (gnt !== 8'h01 || starve !== 1'b0 || p !== 8'h02) begin
            errors++; $display("FAIL guard_ev1 got gnt=%h starve=%b p=%h want 01 0 02", gnt, starve, p);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        checks++; if (p !== 8'h20 || starve !== 1'b1) begin errors++; $display("FAIL guard_ev2 got p=%h starve=%b want 20 1", p, starve); end
        done = 1'b1;
        step();
        done = 1'b0; force_en = 1'b0;
        step();
        checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL guard_grant got %h want 20", gnt); end
        checks++; if (starve !== 1'b0 || p !== 8'h40) begin errors++; $display("FAIL guard_clear got starve=%b p=%h want 0 40", starve, p); end
        r_in = 8'h00;
        step();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rotation();
        test_wrap();
        test_hold_abandon();
        test_error();
        test_reset_mid();
`ifdef STARVE_GUARD_EN
        test_guard();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
